// File: rtl/bsg_link_oddr_phy_if.sv
// Word handshake into the bsg_link transmit DDR PHY.
//   data  : 2*width_p word; [width_p-1:0] is sent first, then the upper half
//   valid : data is valid
//   ready : the PHY takes data on this cycle's clock posedge
// master: word source; slave: the PHY.
interface bsg_link_oddr_phy_if #(
    parameter int width_p = 32
);
    logic [2*width_p-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/bsg_link_oddr_phy.sv
// Transmit-side DDR PHY for bsg_link, the mirror of the IDDR receiver.
// Takes one 2*width_p word every two clk_i cycles and puts it on a width_p
// pin bus, low half first and high half second. A forwarded clock at half
// the clk_i rate is launched from the negedge so that its edges sit in the
// middle of each data slot. The far end captures the low half on the
// clk_r_o posedge and the high half on the clk_r_o negedge.
//
// Ports:
//   clk_i      transmit clock; one pin-bus slot per cycle
//   reset_n_i  asynchronous active-low reset
//   in_if      word handshake (slave side: data, valid in; ready out)
//   data_r_o   registered pin data
//   clk_r_o    registered forwarded clock
module bsg_link_oddr_phy #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    bsg_link_oddr_phy_if.slave in_if,
    output logic [width_p-1:0] data_r_o,
    output logic               clk_r_o
);

    // hi_r = 1: the next posedge is a load edge.
    logic               hi_r;
    logic [width_p-1:0] hi_buf_r;

    // Gated with reset so the source never sees ready while held in reset.
    assign in_if.ready = hi_r & reset_n_i;

    // The phase toggles every cycle whatever the handshake does, so the pin
    // bus never stalls. An idle load slot sends an all-zero pair.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hi_r     <= 1'b1;
            hi_buf_r <= '0;
            data_r_o <= '0;
        end else if (hi_r) begin
            if (in_if.valid) begin
                data_r_o <= in_if.data[width_p-1:0];
                hi_buf_r <= in_if.data[2*width_p-1:width_p];
            end else begin
                data_r_o <= '0;
                hi_buf_r <= '0;
            end
            hi_r <= 1'b0;
        end else begin
            data_r_o <= hi_buf_r;
            hi_r     <= 1'b1;
        end
    end

    // Launched a half cycle after the data, so clk_r_o rises in the middle
    // of the low-half slot and falls in the middle of the high-half slot.
    always_ff @(negedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            clk_r_o <= 1'b0;
        end else begin
            clk_r_o <= ~hi_r;
        end
    end

endmodule

// File: doc/bsg_link_oddr_phy.md
Name: bsg_link_oddr_phy

Overview:
- Transmit-side DDR PHY for bsg_link; the mirror of the IDDR receiver.
- Accepts one 2*width_p word per two clk_i cycles via valid/ready.
- Serializes each word onto a width_p pin bus: low half first, then high half.
- Emits a forwarded clock clk_r_o whose edges fall mid-eye, so the far-end IDDR captures the low half on its posedge and the high half on its negedge, reassembling {high, low}.

Parameters:
- width_p, 32, pin-bus width; input word is 2*width_p.

Ports:
- clk_i  in  1  transmit clock; pin-bus bit rate equals clk_i frequency.
- reset_n_i  in  1  reset, asynchronous, active-low.
- data_i  in  2*width_p  word to send; [width_p-1:0] goes first (low half), [2*width_p-1:width_p] goes second (high half).
- valid_i  in  1  data_i valid.
- ready_o  out  1  block accepts data_i on this cycle's clk_i posedge.
- data_r_o  out  width_p  registered pin data.
- clk_r_o  out  1  registered forwarded clock, half clk_i frequency.

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low (reset_n_i).
- State:
  - hi_r: phase bit; 1 = the next posedge is a load edge.
  - hi_buf_r: width_p holding register for the high half.
  - data_r_o register; clk_r_o register.
- Reset (reset_n_i low, asynchronous, any time): hi_r=1, hi_buf_r=0, data_r_o=0, clk_r_o=0, ready_o=0. Reset mid-word drops the word; there is no partial resend.
- ready_o = hi_r & reset_n_i, combinational from the register. Handshake completes when valid_i & ready_o at a posedge. data_i is only sampled on that edge.
- Posedge with hi_r=1 (load edge):
  - if valid_i: data_r_o<=data_i[width_p-1:0], hi_buf_r<=data_i[2*width_p-1:width_p];
  - else (idle): data_r_o<=0, hi_buf_r<=0;
  - hi_r<=0.
- Posedge with hi_r=0 (high edge): data_r_o<=hi_buf_r, hi_r<=1. valid_i is ignored; ready_o=0.
- hi_r toggles every cycle unconditionally, so the pin bus is never stalled. Idle slots transmit all-zero pairs.
- Negedge clk_i: clk_r_o<=~hi_r. clk_r_o therefore rises mid-low-half and falls mid-high-half (90-degree alignment).
- clk_r_o is the only negedge flop. It is also cleared asynchronously by reset.
- Latency and throughput:
  - word accepted at posedge k: low half on data_r_o during [k, k+1), high half during [k+1, k+2);
  - peak throughput is one word per 2 clk_i cycles.
- First load edge: the first posedge after reset_n_i rises is a load edge. The first clk_r_o rising edge occurs at the following negedge.
- Back-to-back words: ready_o is high every other cycle. Consecutive accepted words produce a continuous pin stream with no gap.
- No combinational path from data_i or valid_i to any output.

Test Plan:
- Reset behaviour: assert reset_n_i low asynchronously mid-cycle with hi_r=0 and data_r_o nonzero -> data_r_o=0, clk_r_o=0 and ready_o=0 immediately. After release, the first posedge is a load edge (ready_o=1 before it).
- Single word (width_p=32): data_i=64'hDEADBEEF_01234567, valid_i at the load edge -> data_r_o=32'h01234567 for one cycle, then 32'hDEADBEEF, then 0. clk_r_o rises at the negedge inside the 01234567 slot and falls inside the DEADBEEF slot.
- Stream: words 64'h1_0, 64'h3_2, 64'h5_4 presented with valid_i held high -> accepted only on ready_o=1 cycles. data_r_o sequence is 0,1,2,3,4,5 with no bubbles. clk_r_o period is 2 clk_i cycles.
- valid_i on the high edge: raise valid_i only while ready_o=0 for one cycle -> no accept, data_r_o stays 0, hi_buf_r is unchanged.
- Loopback: connect data_r_o/clk_r_o to the IDDR receiver (its clk_i=clk_r_o). Send 100 random words -> the receiver's data_r_o reproduces each word in order.
- Reset mid-word: reset after accepting 64'hAAAA5555_12345678 while the low half is on the pins -> the high half is never driven and the pins return to 0.
